// File: rtl/fast_pkg.sv
// Shared constants for the FAST ring fetcher: radius-3 Bresenham circle offsets
// (clockwise from top) and the fetch sequencer state encoding.
package fast_pkg;

    localparam int RING_SIZE = 16;
    localparam int RADIUS    = 3;

    localparam logic signed [2:0] RING_DX [RING_SIZE] = '{
        3'sd0,  3'sd1,  3'sd2,  3'sd3,  3'sd3,  3'sd3,  3'sd2,  3'sd1,
        3'sd0, -3'sd1, -3'sd2, -3'sd3, -3'sd3, -3'sd3, -3'sd2, -3'sd1
    };

    localparam logic signed [2:0] RING_DY [RING_SIZE] = '{
        -3'sd3, -3'sd3, -3'sd2, -3'sd1,  3'sd0,  3'sd1,  3'sd2,  3'sd3,
         3'sd3,  3'sd3,  3'sd2,  3'sd1,  3'sd0, -3'sd1, -3'sd2, -3'sd3
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    // Slot 0 is the centre; slots 1..16 map onto table entries 0..15.
    function automatic logic [3:0] ring_entry(input logic [4:0] idx);
        return 4'(idx - 5'd1);
    endfunction

endpackage

// File: rtl/fast_ring_addr_gen.sv
// Maps (centre, slot index) to an SRAM read address plus a zero-fill flag.
// FAST_RING_CLAMP_BORDER_EN: clamp off-image points to the border instead of zero-filling.
module fast_ring_addr_gen
    import fast_pkg::*;
#(
    parameter int X_MAX = 5,
    parameter int Y_MAX = 5,
    localparam int XW = $clog2(X_MAX),
    localparam int YW = $clog2(Y_MAX)
)(
    input  logic [XW-1:0] cx,
    input  logic [YW-1:0] cy,
    input  logic [4:0]    idx,
    output logic [XW-1:0] ax,
    output logic [YW-1:0] ay,
    output logic          oob
);

    localparam int XS = XW + 2;
    localparam int YS = YW + 2;

    logic signed [2:0]    dx_s;
    logic signed [2:0]    dy_s;
    logic signed [XS-1:0] sx_s;
    logic signed [YS-1:0] sy_s;
    logic signed [XS-1:0] xmax_s;
    logic signed [YS-1:0] ymax_s;
    logic                 oob_x_s;
    logic                 oob_y_s;

    // Offset lookup for the current slot.
    always_comb begin
        dx_s = 3'sd0;
        dy_s = 3'sd0;
        if (idx == 5'd0) begin
            dx_s = 3'sd0;
            dy_s = 3'sd0;
        end else begin
            dx_s = RING_DX[ring_entry(idx)];
            dy_s = RING_DY[ring_entry(idx)];
        end
    end

    assign xmax_s  = XS'(X_MAX - 1);
    assign ymax_s  = YS'(Y_MAX - 1);
    assign sx_s    = $signed({2'b00, cx}) + XS'(dx_s);
    assign sy_s    = $signed({2'b00, cy}) + YS'(dy_s);
    assign oob_x_s = sx_s[XS-1] || (sx_s > xmax_s);
    assign oob_y_s = sy_s[YS-1] || (sy_s > ymax_s);

`ifdef FAST_RING_CLAMP_BORDER_EN
    // Replicate the border: clamp each axis independently, always read.
    always_comb begin
        ax  = sx_s[XW-1:0];
        ay  = sy_s[YW-1:0];
        oob = 1'b0;
        if (sx_s[XS-1]) begin
            ax = {XW{1'b0}};
        end else if (sx_s > xmax_s) begin
            ax = xmax_s[XW-1:0];
        end else begin
            ax = sx_s[XW-1:0];
        end
        if (sy_s[YS-1]) begin
            ay = {YW{1'b0}};
        end else if (sy_s > ymax_s) begin
            ay = ymax_s[YW-1:0];
        end else begin
            ay = sy_s[YW-1:0];
        end
    end
`else
    // Off-image points issue no read and are zero-filled downstream.
    always_comb begin
        ax  = {XW{1'b0}};
        ay  = {YW{1'b0}};
        oob = oob_x_s || oob_y_s;
        if (oob) begin
            ax = {XW{1'b0}};
            ay = {YW{1'b0}};
        end else begin
            ax = sx_s[XW-1:0];
            ay = sy_s[YW-1:0];
        end
    end
`endif

endmodule

// File: rtl/fast_ring_fetch_chk.sv
// Protocol checker for fast_ring_fetch: an accepted centre must lie inside the image.
module fast_ring_fetch_chk #(
    parameter int X_MAX = 5,
    parameter int Y_MAX = 5,
    localparam int XW = $clog2(X_MAX),
    localparam int YW = $clog2(Y_MAX)
)(
    input logic          clk,
    input logic          n_rst,
    input logic          in_valid,
    input logic          in_ready,
    input logic [XW-1:0] in_x,
    input logic [YW-1:0] in_y
);

    a_centre_in_image: assert property (
        @(posedge clk) disable iff (!n_rst)
        (in_valid && in_ready) |-> ((int'(in_x) < X_MAX) && (int'(in_y) < Y_MAX))
    );

endmodule

// File: rtl/fast_ring_fetch.sv
// Fetches a centre pixel plus its radius-3 ring from the image SRAM and hands the
// packed ring to the FAST segment test. Border policy selected by FAST_RING_CLAMP_BORDER_EN.
module fast_ring_fetch
    import fast_pkg::*;
#(
    parameter int PIXEL_DEPTH = 8,
    parameter int X_MAX = 5,
    parameter int Y_MAX = 5,
    localparam int XW = $clog2(X_MAX),
    localparam int YW = $clog2(Y_MAX)
)(
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [XW-1:0]                 in_x,
    input  logic [YW-1:0]                 in_y,
    output logic [XW-1:0]                 sram_x_addr,
    output logic [YW-1:0]                 sram_y_addr,
    output logic                          sram_ren,
    output logic                          sram_wen,
    input  logic [PIXEL_DEPTH-1:0]        sram_rdat,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [PIXEL_DEPTH-1:0]        out_center,
    output logic [16*PIXEL_DEPTH-1:0]     out_ring,
    output logic [XW-1:0]                 out_x,
    output logic [YW-1:0]                 out_y
);

    fetch_state_t            state_r;
    fetch_state_t            next_state_s;
    logic [4:0]              idx_r;
    logic [XW-1:0]           cx_r;
    logic [YW-1:0]           cy_r;
    logic                    in_ready_r;
    logic                    out_valid_r;
    logic                    cap_valid_r;
    logic [4:0]              cap_idx_r;
    logic                    cap_oob_r;
    logic [PIXEL_DEPTH-1:0]  cap_data_s;
    logic [PIXEL_DEPTH-1:0]  center_r;
    logic [PIXEL_DEPTH-1:0]  ring_r [RING_SIZE];
    logic [XW-1:0]           ax_s;
    logic [YW-1:0]           ay_s;
    logic                    oob_s;

    fast_ring_addr_gen #(.X_MAX(X_MAX), .Y_MAX(Y_MAX)) u_addr_gen (
        .cx  (cx_r),
        .cy  (cy_r),
        .idx (idx_r),
        .ax  (ax_s),
        .ay  (ay_s),
        .oob (oob_s)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: one centre at a time, no overlap.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (in_valid && in_ready_r) next_state_s = FETCH; else next_state_s = IDLE;
            FETCH:   if (idx_r == 5'd16) next_state_s = DRAIN; else next_state_s = FETCH;
            DRAIN:   next_state_s = HOLD;
            HOLD:    if (out_ready) next_state_s = IDLE; else next_state_s = HOLD;
            default: next_state_s = IDLE;
        endcase
    end

    // Read-slot outputs; the address generator already zeroes off-image addresses.
    always_comb begin
        sram_ren    = 1'b0;
        sram_x_addr = {XW{1'b0}};
        sram_y_addr = {YW{1'b0}};
        case (state_r)
            FETCH: begin
                sram_ren    = !oob_s;
                sram_x_addr = ax_s;
                sram_y_addr = ay_s;
            end
            default: begin
                sram_ren    = 1'b0;
                sram_x_addr = {XW{1'b0}};
                sram_y_addr = {YW{1'b0}};
            end
        endcase
    end

    // Handshake flags registered from the next state, so both are low during reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == IDLE);
            out_valid_r <= (next_state_s == HOLD);
        end
    end

    // Centre latch and slot counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cx_r  <= {XW{1'b0}};
            cy_r  <= {YW{1'b0}};
            idx_r <= 5'd0;
        end else if ((state_r == IDLE) && in_valid && in_ready_r) begin
            cx_r  <= in_x;
            cy_r  <= in_y;
            idx_r <= 5'd0;
        end else if ((state_r == FETCH) && (idx_r != 5'd16)) begin
            idx_r <= idx_r + 5'd1;
        end else begin
            idx_r <= idx_r;
        end
    end

    assign cap_data_s = cap_oob_r ? {PIXEL_DEPTH{1'b0}} : sram_rdat;

    // Capture pipeline: slot tag follows the read by one cycle to meet the SRAM data.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cap_valid_r <= 1'b0;
            cap_idx_r   <= 5'd0;
            cap_oob_r   <= 1'b0;
            center_r    <= {PIXEL_DEPTH{1'b0}};
            for (int k = 0; k < RING_SIZE; k++) begin
                ring_r[k] <= {PIXEL_DEPTH{1'b0}};
            end
        end else begin
            cap_valid_r <= (state_r == FETCH);
            cap_idx_r   <= idx_r;
            cap_oob_r   <= oob_s;
            if (cap_valid_r) begin
                if (cap_idx_r == 5'd0) begin
                    center_r <= cap_data_s;
                end
                for (int k = 0; k < RING_SIZE; k++) begin
                    if (cap_idx_r == 5'(k + 1)) begin
                        ring_r[k] <= cap_data_s;
                    end
                end
            end
        end
    end

    // Pack ring points, point 1 in the least significant byte lane.
    always_comb begin
        out_ring = {(16*PIXEL_DEPTH){1'b0}};
        for (int k = 0; k < RING_SIZE; k++) begin
            out_ring[k*PIXEL_DEPTH +: PIXEL_DEPTH] = ring_r[k];
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_center = center_r;
    assign out_x      = cx_r;
    assign out_y      = cy_r;
    assign sram_wen   = 1'b0;

endmodule

// File: tb/tb_fast_ring_fetch.sv
// Directed bench for fast_ring_fetch on a 16x16 image with pixel = x + 16*y.
module tb_fast_ring_fetch;

    localparam int PD = 8;
    localparam int XM = 16;
    localparam int YM = 16;
    localparam int TDX [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int TDY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [3:0]    in_x = 4'd0;
    logic [3:0]    in_y = 4'd0;
    logic [3:0]    sram_x_addr;
    logic [3:0]    sram_y_addr;
    logic          sram_ren;
    logic          sram_wen;
    logic [PD-1:0] sram_rdat = 8'hEE;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PD-1:0] out_center;
    logic [127:0]  out_ring;
    logic [3:0]    out_x;
    logic [3:0]    out_y;

    int tests = 0;
    int fails = 0;
    int ren_cnt = 0;
    int lat;

    always #5 clk = ~clk;

    fast_ring_fetch #(.PIXEL_DEPTH(PD), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .sram_x_addr(sram_x_addr), .sram_y_addr(sram_y_addr),
        .sram_ren(sram_ren), .sram_wen(sram_wen), .sram_rdat(sram_rdat),
        .out_valid(out_valid), .out_ready(out_ready), .out_center(out_center),
        .out_ring(out_ring), .out_x(out_x), .out_y(out_y)
    );

    fast_ring_fetch_chk #(.X_MAX(XM), .Y_MAX(YM)) u_chk (
        .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y)
    );

    // Synchronous-read SRAM model; idle cycles return a poison value.
    always @(posedge clk) begin
        if (sram_ren) sram_rdat <= 8'(32'(sram_x_addr) + 32'(sram_y_addr) * 16);
        else          sram_rdat <= 8'hEE;
    end

    // Reads issued since the last accepted centre.
    always @(posedge clk) begin
        if (in_valid && in_ready) ren_cnt <= 0;
        else if (sram_ren)        ren_cnt <= ren_cnt + 1;
    end

    function automatic logic [7:0] exp_pix(input int x, input int y);
        int cx = x;
        int cy = y;
`ifdef FAST_RING_CLAMP_BORDER_EN
        cx = (x < 0) ? 0 : ((x > XM - 1) ? XM - 1 : x);
        cy = (y < 0) ? 0 : ((y > YM - 1) ? YM - 1 : y);
`else
        if (x < 0 || x > XM - 1 || y < 0 || y > YM - 1) return 8'h00;
`endif
        return 8'((cx + 16 * cy) & 255);
    endfunction

    function automatic logic [127:0] exp_ring(input int x, input int y);
        logic [127:0] r = 128'd0;
        for (int k = 0; k < 16; k++) r[k*8 +: 8] = exp_pix(x + TDX[k], y + TDY[k]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Offer a centre, complete the handshake, and count cycles until out_valid.
    task automatic fetch(input int x, input int y, output int cycles);
        int w = 0;
        in_x = 4'(x);
        in_y = 4'(y);
        in_valid = 1'b1;
        while (!in_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        chk("accept_wait", 128'(w < 50), 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cycles = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk); #1; cycles++;
        end
    endtask

    task automatic check_result(input string tag, input int x, input int y);
        chk({tag, "_valid"},  128'(out_valid), 128'd1);
        chk({tag, "_center"}, 128'(out_center), 128'(exp_pix(x, y)));
        chk({tag, "_ring"},   out_ring, exp_ring(x, y));
        chk({tag, "_xy"},     128'({out_x, out_y}), 128'({4'(x), 4'(y)}));
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid_drop", 128'(out_valid), 128'd0);
        chk("release_ready",      128'(in_ready), 128'd1);
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_in_ready",  128'(in_ready), 128'd0);
        chk("rst_out_valid", 128'(out_valid), 128'd0);
        chk("rst_ren",       128'(sram_ren), 128'd0);
        chk("rst_outputs",   {out_ring, 8'(out_center), 4'(out_x), 4'(out_y)} , 128'd0);
        chk("rst_wen",       128'(sram_wen), 128'd0);
        #19 n_rst = 1'b1;
        @(posedge clk); #1;
        chk("idle_in_ready", 128'(in_ready), 128'd1);

        // Interior centre (8,8)
        fetch(8, 8, lat);
        chk("c88_latency", 128'(lat), 128'd18);
        check_result("c88", 8, 8);
        chk("c88_center_hand", 128'(out_center), 128'h88);
        chk("c88_p1",  128'(out_ring[7:0]),   128'h58);
        chk("c88_p5",  128'(out_ring[39:32]), 128'h8B);
        chk("c88_p9",  128'(out_ring[71:64]), 128'hB8);
        chk("c88_p13", 128'(out_ring[103:96]), 128'h85);
        chk("c88_ren_cnt", 128'(ren_cnt), 128'd17);
        release_result();

        // Top-left corner (0,0)
        fetch(0, 0, lat);
        chk("c00_latency", 128'(lat), 128'd18);
        check_result("c00", 0, 0);
        chk("c00_p5", 128'(out_ring[39:32]), 128'h03);
        chk("c00_p9", 128'(out_ring[71:64]), 128'h30);
`ifdef FAST_RING_CLAMP_BORDER_EN
        chk("c00_p1_clamp",  128'(out_ring[7:0]),    128'h00);
        chk("c00_p13_clamp", 128'(out_ring[103:96]), 128'h00);
        chk("c00_p4_clamp",  128'(out_ring[31:24]),  128'h03);
        chk("c00_ren_cnt",   128'(ren_cnt), 128'd17);
`else
        chk("c00_zero_pts", {out_ring[127:72], out_ring[7:0]}, 128'd0);
        chk("c00_ren_cnt",  128'(ren_cnt), 128'd6);
`endif
        release_result();

        // Bottom-right mixed-boundary centre
        fetch(14, 15, lat);
        check_result("c1415", 14, 15);
        release_result();

        // Back-pressure in HOLD with a second centre already offered
        fetch(8, 8, lat);
        in_x = 4'd3;
        in_y = 4'd4;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_result("stall", 8, 8);
            chk("stall_in_ready", 128'(in_ready), 128'd0);
        end
        release_result();
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("next_taken", 128'(in_ready), 128'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk("c34_latency", 128'(lat), 128'd18);
        check_result("c34", 3, 4);
        release_result();

        // Reset in the middle of a fetch
        in_x = 4'd10;
        in_y = 4'd6;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("mid_ren_before", 128'(sram_ren), 128'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("mid_rst_ren",   128'(sram_ren), 128'd0);
        chk("mid_rst_valid", 128'(out_valid), 128'd0);
        chk("mid_rst_ready", 128'(in_ready), 128'd0);
        chk("mid_rst_ring",  out_ring, 128'd0);
        #2 n_rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", 128'(in_ready), 128'd1);
        fetch(5, 10, lat);
        chk("c510_latency", 128'(lat), 128'd18);
        check_result("c510", 5, 10);
        release_result();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
